// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
//
// Multi-cycle execute-stage ALU. Operands and control are registered on an
// accepted Start. The ALU keeps its own NZCV flag register and applies an
// ARM-style condition check before it executes. MUL is an iterative shift-add
// multiplier that handles one multiplier bit per cycle. Every other operation
// completes one cycle after it is accepted.
//
// Parameters
//   WIDTH     datapath width (>= 8, power of two)
//   FLAG_RST  reset value of the NZCV register, ordered {N,Z,C,V}
//
// Ports
//   Clk       clock, rising edge
//   Reset     synchronous, active-high reset
//   Start     issue request, accepted only while Busy=0
//   OpCode    operation select
//   Cond      condition code, checked against the flags when Start is accepted
//   S         1 = write flags (CMP always writes them)
//   Reg1      operand A
//   Reg2      operand B, also the shift source
//   IV        16-bit immediate; its low bits are the shift amount
//   Result    registered result
//   Flag      registered NZCV
//   Busy      high while a multiply is in progress
//   Done      one-cycle completion pulse
//   Executed  qualifies Done: 1 = condition passed and the op ran
// ----------------------------------------------------------------------------
module seq_alu #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       OpCode,
  input  logic [3:0]       Cond,
  input  logic             S,
  input  logic [WIDTH-1:0] Reg1,
  input  logic [WIDTH-1:0] Reg2,
  input  logic [15:0]      IV,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flag,
  output logic             Busy,
  output logic             Done,
  output logic             Executed
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOVI = 4'h6;
  localparam logic [3:0] OP_MOVB = 4'h7;
  localparam logic [3:0] OP_LSR  = 4'h8;
  localparam logic [3:0] OP_LSL  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  state_t state;

  // Captured request
  logic [3:0]       op_q;
  logic             s_q;
  logic             pass_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [15:0]      iv_q;

  // Multiplier datapath
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0]   step_cnt;
  logic [WIDTH-1:0] acc_next;
  logic [3:0]       mul_flag;

  // Single-cycle execute datapath
  logic [SHW-1:0]   sh;
  logic [SHW-1:0]   sh_m1;
  logic [SHW-1:0]   sh_neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] calc;
  logic             wr_res;
  logic             wr_flag;
  logic             c_new;
  logic             v_new;
  logic [WIDTH-1:0] exec_res;
  logic [3:0]       exec_flag;

  // Issue control
  logic [3:0]       flag_fwd;
  logic             start_pass;
  logic             accept;

  // ARM condition table. Flags are ordered {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cc)
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = !z;
      4'h2:    cond_ok = c;
      4'h3:    cond_ok = !c;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = !n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = !v;
      4'h8:    cond_ok = c && !z;
      4'h9:    cond_ok = !c || z;
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = !z && (n == v);
      4'hD:    cond_ok = z || (n != v);
      default: cond_ok = 1'b1;
    endcase
  endfunction

  // Single-cycle execute. This block computes the result and flags that the
  // captured op writes at the end of its EXEC cycle. A failed condition or a
  // reserved opcode leaves Result and Flag as they are.
  // sh_neg is (WIDTH - sh) modulo WIDTH. It is the bit index that an LSL
  // shifts out last, and it is the left-shift half of a rotate. When sh = 0
  // it is 0, so the rotate collapses to the source value.
  always_comb begin
    sh      = iv_q[SHW-1:0];
    sh_m1   = sh - SHW'(1);
    sh_neg  = '0 - sh;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    calc    = Result;
    wr_res  = 1'b0;
    wr_flag = s_q;
    c_new   = Flag[1];
    v_new   = Flag[0];
    case (op_q)
      OP_ADD: begin
        calc   = sum[WIDTH-1:0];
        wr_res = 1'b1;
        c_new  = sum[WIDTH];
        v_new  = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        calc    = diff[WIDTH-1:0];
        wr_res  = (op_q == OP_SUB);
        wr_flag = s_q || (op_q == OP_CMP);
        c_new   = !diff[WIDTH];
        v_new   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
      end
      OP_ORR: begin
        calc   = a_q | b_q;
        wr_res = 1'b1;
      end
      OP_AND: begin
        calc   = a_q & b_q;
        wr_res = 1'b1;
      end
      OP_XOR: begin
        calc   = a_q ^ b_q;
        wr_res = 1'b1;
      end
      OP_MOVI: begin
        calc   = WIDTH'(iv_q);
        wr_res = 1'b1;
      end
      OP_MOVB: begin
        calc   = b_q;
        wr_res = 1'b1;
      end
      OP_LSR: begin
        calc   = b_q >> sh;
        wr_res = 1'b1;
        if (sh != '0) begin
          c_new = b_q[sh_m1];
        end
      end
      OP_LSL: begin
        calc   = b_q << sh;
        wr_res = 1'b1;
        if (sh != '0) begin
          c_new = b_q[sh_neg];
        end
      end
      OP_ROR: begin
        calc   = (b_q >> sh) | (b_q << sh_neg);
        wr_res = 1'b1;
        if (sh != '0) begin
          c_new = b_q[sh_m1];
        end
      end
      default: begin
        wr_flag = 1'b0;
      end
    endcase
    exec_res  = (wr_res && pass_q) ? calc : Result;
    exec_flag = (wr_flag && pass_q) ? {calc[MSB], (calc == '0), c_new, v_new} : Flag;
  end

  // One shift-add step. The accumulator is WIDTH bits wide, so the final
  // value is the product modulo 2^WIDTH. MUL writes only N and Z.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    mul_flag = s_q ? {acc_next[MSB], (acc_next == '0), Flag[1:0]} : Flag;
  end

  // A request can be accepted during the EXEC cycle of the previous op. Its
  // condition is therefore judged against the flags that the previous op is
  // about to write, which keeps back-to-back ops in program order.
  always_comb begin
    flag_fwd   = (state == EXEC) ? exec_flag : Flag;
    start_pass = cond_ok(Cond, flag_fwd);
    accept     = Start && !Busy;
  end

  // Control FSM and all architectural registers. An accepted Start in the
  // same cycle as an EXEC completion overrides the return to IDLE, so
  // single-cycle ops can issue every cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      Result   <= '0;
      Flag     <= FLAG_RST;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Executed <= 1'b0;
      step_cnt <= '0;
      op_q     <= '0;
      s_q      <= 1'b0;
      pass_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      iv_q     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      Done     <= 1'b0;
      Executed <= 1'b0;
      case (state)
        EXEC: begin
          Result   <= exec_res;
          Flag     <= exec_flag;
          Done     <= 1'b1;
          Executed <= pass_q;
          state    <= IDLE;
        end
        MUL: begin
          acc      <= acc_next;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          step_cnt <= step_cnt + SHW'(1);
          if (step_cnt == SHW'(WIDTH - 1)) begin
            Result   <= acc_next;
            Flag     <= mul_flag;
            Done     <= 1'b1;
            Executed <= 1'b1;
            Busy     <= 1'b0;
            step_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: begin
        end
      endcase

      if (accept) begin
        op_q   <= OpCode;
        s_q    <= S;
        pass_q <= start_pass;
        a_q    <= Reg1;
        b_q    <= Reg2;
        iv_q   <= IV;
        // A multiply whose condition fails takes the single-cycle path and
        // only reports Executed=0.
        if ((OpCode == OP_MUL) && start_pass) begin
          state    <= MUL;
          Busy     <= 1'b1;
          acc      <= '0;
          mcand    <= Reg1;
          mplier   <= Reg2;
          step_cnt <= '0;
        end else begin
          state <= EXEC;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
//
// Scoreboard bench for seq_alu (WIDTH=32). Stimulus tasks issue operations.
// For each one they push the expected completion cycle, Result, Flag and
// Executed, taken from an arithmetic reference model. A negedge monitor pops
// and compares these entries whenever Done is high. It reports a Done with no
// pending entry, and an entry whose cycle passes without a Done.
// ----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int         W        = 32;
  localparam logic [3:0] FLAG_RST = 4'b0000;

  logic          clk;
  logic          Reset;
  logic          Start;
  logic [3:0]    OpCode;
  logic [3:0]    Cond;
  logic          S;
  logic [W-1:0]  Reg1;
  logic [W-1:0]  Reg2;
  logic [15:0]   IV;
  logic [W-1:0]  Result;
  logic [3:0]    Flag;
  logic          Busy;
  logic          Done;
  logic          Executed;

  seq_alu #(.WIDTH(W), .FLAG_RST(FLAG_RST)) dut (
    .Clk      (clk),
    .Reset    (Reset),
    .Start    (Start),
    .OpCode   (OpCode),
    .Cond     (Cond),
    .S        (S),
    .Reg1     (Reg1),
    .Reg2     (Reg2),
    .IV       (IV),
    .Result   (Result),
    .Flag     (Flag),
    .Busy     (Busy),
    .Done     (Done),
    .Executed (Executed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    int          lat;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        ex;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] m_res;
  logic [3:0]  m_flag;

  // Counts rising edges, so that the monitor can check completion latency.
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Reference model. It works on 64-bit arithmetic: carries come from bit 32,
  // and signed overflow means the true signed result differs from the
  // wrapped 32-bit value.
  task automatic model_op(input logic [3:0] op, input logic [3:0] cc, input logic s,
                          input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv,
                          output exp_t e);
    logic [63:0] ua, ub, r;
    longint      sa, sbv, sr;
    int          sh;
    logic        c, v, wr_res, wr_flg;
    logic [31:0] res;
    ua     = {32'd0, a};
    ub     = {32'd0, b};
    sa     = longint'($signed(a));
    sbv    = longint'($signed(b));
    sh     = int'(iv[4:0]);
    c      = m_flag[1];
    v      = m_flag[0];
    r      = '0;
    sr     = 0;
    wr_res = 1'b0;
    wr_flg = 1'b0;
    e.cyc  = 0;
    e.lat  = 1;
    e.ex   = cond_holds(cc, m_flag);
    if (e.ex) begin
      wr_res = 1'b1;
      wr_flg = s;
      case (op)
        4'h0: begin
          r  = ua + ub;
          c  = r[32];
          sr = sa + sbv;
          v  = (sr != longint'($signed(r[31:0])));
        end
        4'h1, 4'hB: begin
          r  = ua - ub;
          c  = (a >= b);
          sr = sa - sbv;
          v  = (sr != longint'($signed(r[31:0])));
          if (op == 4'hB) begin
            wr_res = 1'b0;
            wr_flg = 1'b1;
          end
        end
        4'h2: begin
          r     = ua * ub;
          e.lat = W;
        end
        4'h3: r = ua | ub;
        4'h4: r = ua & ub;
        4'h5: r = ua ^ ub;
        4'h6: r = {48'd0, iv};
        4'h7: r = ub;
        4'h8: begin
          r = ub >> sh;
          if (sh != 0) c = b[sh-1];
        end
        4'h9: begin
          r = ub << sh;
          if (sh != 0) c = b[32-sh];
        end
        4'hA: begin
          r = (ub >> sh) | (ub << (32 - sh));
          if (sh != 0) c = r[31];
        end
        default: begin
          wr_res = 1'b0;
          wr_flg = 1'b0;
        end
      endcase
    end
    res = r[31:0];
    if (wr_flg) m_flag = {res[31], (res == 32'd0), c, v};
    if (wr_res) m_res = res;
    e.res = m_res;
    e.flg = m_flag;
  endtask

  // Must be called just after a rising edge. It drives one request through
  // the next edge, records the expected response, and returns just after
  // that edge with Start low.
  task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] cc, input logic s,
                                input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv);
    exp_t e;
    model_op(op, cc, s, a, b, iv, e);
    OpCode = op;
    Cond   = cc;
    S      = s;
    Reg1   = a;
    Reg2   = b;
    IV     = iv;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc + e.lat;
    sb.push_back(e);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every Done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL spurious_done: got Done=1, expected no completion (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check_output("done_cycle", cyc, mon_e.cyc);
        check_output("result", Result, mon_e.res);
        check_output("flag", {28'd0, Flag}, {28'd0, mon_e.flg});
        check_output("executed", {31'd0, Executed}, {31'd0, mon_e.ex});
        check_output("busy_at_done", {31'd0, Busy}, 32'd0);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      total++;
      bad++;
      $display("[TB] FAIL missing_done: got no Done, expected one at cycle %0d", sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    int          op;

    Reset  = 1'b1;
    Start  = 1'b0;
    OpCode = '0;
    Cond   = '0;
    S      = 1'b0;
    Reg1   = '0;
    Reg2   = '0;
    IV     = '0;
    m_res  = '0;
    m_flag = FLAG_RST;

    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    check_output("rst_result", Result, 32'd0);
    check_output("rst_flag", {28'd0, Flag}, {28'd0, FLAG_RST});
    check_output("rst_busy", {31'd0, Busy}, 32'd0);
    check_output("rst_done", {31'd0, Done}, 32'd0);
    check_output("rst_executed", {31'd0, Executed}, 32'd0);
    @(posedge clk);
    #1;

    // ADD with signed overflow
    apply_stimulus(4'h0, 4'hE, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0);
    wait_idle();
    check_output("add_ovf_res", Result, 32'h8000_0000);
    check_output("add_ovf_flag", {28'd0, Flag}, 32'h9);

    // CMP sets Z and C with S=0, then conditional SUBs
    apply_stimulus(4'hB, 4'hE, 1'b0, 32'd5, 32'd5, 16'h0);
    wait_idle();
    check_output("cmp_res_kept", Result, 32'h8000_0000);
    check_output("cmp_flag", {28'd0, Flag}, 32'h6);
    apply_stimulus(4'h1, 4'h0, 1'b0, 32'd3, 32'd7, 16'h0);
    wait_idle();
    check_output("sub_eq_res", Result, 32'hFFFF_FFFC);
    apply_stimulus(4'h1, 4'h1, 1'b0, 32'd3, 32'd8, 16'h0);
    wait_idle();
    check_output("sub_ne_res_kept", Result, 32'hFFFF_FFFC);

    // MUL with busy tracking and an ignored mid-operation Start
    apply_stimulus(4'h2, 4'hE, 1'b1, 32'h0001_0001, 32'h0001_0001, 16'h0);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) begin
        OpCode = 4'h0;
        Cond   = 4'hE;
        S      = 1'b1;
        Reg1   = 32'd1;
        Reg2   = 32'd1;
        Start  = 1'b1;
      end
      if (i == 5) Start = 1'b0;
      @(negedge clk);
      check_output("mul_busy", {31'd0, Busy}, (i < W) ? 32'd1 : 32'd0);
    end
    wait_idle();
    check_output("mul_res", Result, 32'h0002_0001);
    check_output("mul_flag", {28'd0, Flag}, 32'h2);

    // Shifts
    apply_stimulus(4'h0, 4'hE, 1'b1, 32'd0, 32'd0, 16'h0);
    wait_idle();
    apply_stimulus(4'h8, 4'hE, 1'b1, 32'd0, 32'h8000_0001, 16'd1);
    wait_idle();
    check_output("lsr_res", Result, 32'h4000_0000);
    check_output("lsr_flag", {28'd0, Flag}, 32'h2);
    apply_stimulus(4'hA, 4'hE, 1'b1, 32'd0, 32'h0000_000F, 16'd4);
    wait_idle();
    check_output("ror_res", Result, 32'hF000_0000);
    check_output("ror_flag", {28'd0, Flag}, 32'hA);
    apply_stimulus(4'h0, 4'hE, 1'b1, 32'd1, 32'd1, 16'h0);
    wait_idle();
    apply_stimulus(4'h9, 4'hE, 1'b1, 32'd0, 32'h8000_0000, 16'd0);
    wait_idle();
    check_output("lsl0_res", Result, 32'h8000_0000);
    check_output("lsl0_flag", {28'd0, Flag}, 32'h8);

    // Reset during MUL cycle 10
    apply_stimulus(4'h2, 4'hE, 1'b1, 32'd1234, 32'd5678, 16'h0);
    repeat (9) @(posedge clk);
    #1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    m_res  = '0;
    m_flag = FLAG_RST;
    Reset  = 1'b0;
    @(negedge clk);
    check_output("midrst_result", Result, 32'd0);
    check_output("midrst_flag", {28'd0, Flag}, {28'd0, FLAG_RST});
    check_output("midrst_busy", {31'd0, Busy}, 32'd0);
    check_output("midrst_done", {31'd0, Done}, 32'd0);
    check_output("midrst_executed", {31'd0, Executed}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    apply_stimulus(4'h0, 4'hE, 1'b1, 32'd2, 32'd3, 16'h0);
    wait_idle();
    check_output("post_rst_add", Result, 32'd5);

    // Reset and Start together: reset wins
    Reset  = 1'b1;
    OpCode = 4'h0;
    Cond   = 4'hE;
    S      = 1'b1;
    Reg1   = 32'd1;
    Reg2   = 32'd1;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Reset  = 1'b0;
    Start  = 1'b0;
    m_res  = '0;
    m_flag = FLAG_RST;
    @(negedge clk);
    check_output("rst_start_result", Result, 32'd0);
    check_output("rst_start_done0", {31'd0, Done}, 32'd0);
    @(negedge clk);
    check_output("rst_start_done1", {31'd0, Done}, 32'd0);
    @(posedge clk);
    #1;

    // Randomized single ops, each drained before the next
    for (int i = 0; i < 40; i++) begin
      ra = rand_operand();
      rb = ($urandom_range(0, 4) == 0) ? ra : rand_operand();
      apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), ra, rb, 16'($urandom));
      wait_idle();
    end

    // Back-to-back single-cycle ops, one issue per cycle
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 15);
      if (op == 2) op = 7;
      apply_stimulus(4'(op), 4'hE, 1'($urandom_range(0, 1)),
                     rand_operand(), rand_operand(), 16'($urandom));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the combinational execute-stage ALU. It adds registered operands, an internal NZCV flag register, ARM-style condition evaluation and an iterative shift-add multiplier. A Start/Busy/Done handshake lets the control unit issue one operation at a time. It sits between register-file read and write-back.

## Interface
- WIDTH, 32, datapath width (≥8, power of two)
- FLAG_RST, 4'b0000, reset value of the NZCV register {N,Z,C,V}
- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  issue request; sampled only when Busy=0
- OpCode  in  4  operation select
- Cond  in  4  condition code
- S  in  1  1 = update flags (CMP always updates)
- Reg1  in  WIDTH  operand A
- Reg2  in  WIDTH  operand B / shift source
- IV  in  16  immediate / shift amount
- Result  out  WIDTH  registered result
- Flag  out  4  registered NZCV
- Busy  out  1  multi-cycle op in progress
- Done  out  1  one-cycle completion pulse
- Executed  out  1  qualifies Done: 1 = condition passed

## Operation
- Operands, OpCode, Cond and S are captured on the Start edge. Later input changes are ignored.
- The condition is evaluated against Flag at capture time:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E, F always
- Condition fail: Done=1, Executed=0; Result and Flag unchanged; single-cycle even for MUL.
- OpCodes:
  - 0 ADD A+B; 1 SUB A−B; 2 MUL low WIDTH bits of A*B
  - 3 ORR; 4 AND; 5 XOR
  - 6 MOV zero-extended IV; 7 MOV B
  - 8 LSR B by sh; 9 LSL B by sh; A ROR B by sh, where sh = IV[$clog2(WIDTH)-1:0]
  - B CMP A−B: Result unchanged, flags always written
  - C–F reserved: Done=1, Executed=1, Result and Flag unchanged
- Flags are written only when S=1, or for CMP:
  - N = Result MSB; Z = (Result==0)
  - ADD: C = carry out, V = signed overflow
  - SUB/CMP: C = no-borrow (A≥B unsigned), V = signed overflow
  - Shifts: C = last bit shifted out; C unchanged if sh=0. V unchanged.
  - Logic, MOV, MUL: C and V unchanged.
- MUL uses an iterative shift-add over WIDTH steps, one multiplier bit per cycle, with a WIDTH-bit accumulator (modulo 2^WIDTH).
- States:
  - IDLE → EXEC on Start (non-MUL, or condition fail)
  - IDLE → MUL on Start (MUL, condition pass)
  - EXEC → IDLE after 1 cycle
  - MUL → IDLE when the step counter reaches WIDTH−1

## Timing
- Reset values: Result=0, Flag=FLAG_RST, Busy=0, Done=0, Executed=0; state IDLE; step counter 0.
- Single-cycle op, Start sampled at edge k:
  - Result, Flag, Done and Executed are valid after edge k+1.
  - Done is high for exactly one cycle.
  - Busy stays 0.
- MUL, Start at edge k:
  - Busy=1 after edge k+1.
  - At edge k+WIDTH, Busy→0, Done=1, Result/Flag updated. Latency = WIDTH cycles.
- Start while Busy=1 is ignored and not queued.
- Start in the same cycle Done=1 is accepted; back-to-back single-cycle ops give one result per cycle.
- Reset mid-MUL: abort, no Done, outputs return to reset values on the next edge.
- Reset and Start together: Reset wins.

## Test plan
- Reset with WIDTH=32, FLAG_RST=0 → Result=0, Flag=0000, Busy=0, Done=0.
- ADD, S=1, 0x7FFFFFFF + 0x00000001 → Result=0x80000000, Flag N=1 Z=0 C=0 V=1, Done one cycle after Start.
- CMP 5 vs 5, S=0; then SUB 3−7 with Cond=EQ:
  - CMP → Flag Z=1 C=1, Result unchanged.
  - SUB → executes, Result=0xFFFFFFFC.
  - Repeat the SUB with Cond=NE → Executed=0, Result unchanged.
- MUL 0x00010001 × 0x00010001, S=1:
  - Busy for 32 cycles, Result=0x00020001, Z=0, C/V unchanged.
  - Start pulsed mid-operation is ignored.
- LSR B=0x80000001 by IV=1, S=1 → Result=0x40000000, C=1. ROR by IV=4 of 0x0000000F → 0xF0000000. LSL by IV=0 → C unchanged.
- Reset asserted at MUL cycle 10 → no Done, outputs at reset values. A following ADD completes normally.
